// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types -- shared types for the memory issue queue.
//
// Contents:
//   MEMQ_DEPTH            default number of memory issue queue slots
//   ROB_IDX_W             width of a reorder-buffer tag
//   reservation_station_t a dispatched load/store with operand tags/ready/data
//   cdb                   common data bus broadcast (valid, rob_idx, data, flush)
//   memq_slot_t           one queue slot: entry, live operand ready flags, valid
//   memq_capture()        applies a CDB broadcast to a slot's waiting operands
//   memq_ready()          true when a slot holds an op with all needed operands
// ---------------------------------------------------------------------------
package rv32i_types;

  localparam int MEMQ_DEPTH = 8;
  localparam int ROB_IDX_W  = 5;

  typedef struct packed {
    logic                 is_store;   // 1 = store, 0 = load
    logic [2:0]           funct3;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [ROB_IDX_W-1:0] rs1_tag;
    logic                 rs1_ready;
    logic [31:0]          rs1_data;
    logic [ROB_IDX_W-1:0] rs2_tag;
    logic                 rs2_ready;
    logic [31:0]          rs2_data;
    logic [31:0]          imm;
  } reservation_station_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          data;
    logic                 flush;
  } cdb;

  typedef struct packed {
    reservation_station_t entry;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic                 valid;
  } memq_slot_t;

  // Fill any waiting operand whose tag matches the broadcast. The ready flag
  // inside the entry is kept in step so the issued op reports true readiness.
  function automatic memq_slot_t memq_capture(memq_slot_t s, cdb c);
    memq_slot_t r;
    r = s;
    if (c.valid && s.valid && !s.rs1_rdy && (s.entry.rs1_tag == c.rob_idx)) begin
      r.rs1_rdy         = 1'b1;
      r.entry.rs1_ready = 1'b1;
      r.entry.rs1_data  = c.data;
    end else begin
      r.rs1_rdy = s.rs1_rdy;
    end
    if (c.valid && s.valid && !s.rs2_rdy && (s.entry.rs2_tag == c.rob_idx)) begin
      r.rs2_rdy         = 1'b1;
      r.entry.rs2_ready = 1'b1;
      r.entry.rs2_data  = c.data;
    end else begin
      r.rs2_rdy = s.rs2_rdy;
    end
    return r;
  endfunction

  // Loads only need the address operand; stores also need the store data.
  function automatic logic memq_ready(memq_slot_t s);
    return s.valid && s.rs1_rdy && (s.rs2_rdy || !s.entry.is_store);
  endfunction

endpackage

// File: rtl/memq_slot.sv
// ---------------------------------------------------------------------------
// memq_slot -- one storage slot of the memory issue queue.
//
// Holds a single load/store and snoops the CDB every cycle to fill waiting
// operands. An op written in the same cycle as a matching broadcast is
// stored with the broadcast data already captured.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_en      write wr_entry into this slot (enqueue at tail)
//   wr_entry   op being enqueued
//   deq_en     this slot is the head and is leaving the queue
//   cdbus      writeback broadcast; flush empties the slot
//   slot       current slot contents
// ---------------------------------------------------------------------------
module memq_slot
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  reservation_station_t wr_entry,
  input  logic                 deq_en,
  input  cdb                   cdbus,
  output memq_slot_t           slot
);

  memq_slot_t slot_r;
  memq_slot_t wr_slot;

  // Form the incoming slot from the dispatched op's own ready flags.
  always_comb begin
    wr_slot         = '0;
    wr_slot.entry   = wr_entry;
    wr_slot.rs1_rdy = wr_entry.rs1_ready;
    wr_slot.rs2_rdy = wr_entry.rs2_ready;
    wr_slot.valid   = 1'b1;
  end

  // Slot storage: flush/reset clear it, otherwise write, drain or snoop.
  always_ff @(posedge clk) begin
    if (rst || cdbus.flush) begin
      slot_r <= '0;
    end else if (wr_en) begin
      slot_r <= memq_capture(wr_slot, cdbus);
    end else if (deq_en) begin
      slot_r <= '0;
    end else begin
      slot_r <= memq_capture(slot_r, cdbus);
    end
  end

  assign slot = slot_r;

endmodule

// File: rtl/mem_issue_queue.sv
// ---------------------------------------------------------------------------
// mem_issue_queue -- in-order issue queue for loads and stores.
//
// Circular FIFO of DEPTH slots. Ops are dispatched at the tail, wait for
// their operands on the CDB, and are presented to the memory unit strictly
// from the head. A CDB flush empties the queue.
//
// Parameters:
//   DEPTH           number of slots (power of two, 2..16)
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   dispatch_valid  an op is offered from rename/dispatch
//   dispatch_entry  the offered op
//   full            no dispatch is accepted this cycle
//   cdbus           writeback broadcast (valid, rob_idx, data, flush)
//   mem_stall       the memory unit does not take the presented op
//   issue_valid     head op is presented to the memory unit
//   issue_entry     head op with resolved operands; zero when not valid
// Configuration macro:
//   MEMQ_CDB_BYPASS_EN  forward a same-cycle CDB broadcast into the head op
//                       so it can issue in the broadcast cycle
// ---------------------------------------------------------------------------
module mem_issue_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = MEMQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_valid,
  input  reservation_station_t dispatch_entry,
  output logic                 full,
  input  cdb                   cdbus,
  input  logic                 mem_stall,
  output logic                 issue_valid,
  output reservation_station_t issue_entry
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             enq;
  logic             deq;
  memq_slot_t       slots [DEPTH];
  memq_slot_t       head_slot;
  memq_slot_t       head_view;

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  // Full when the indices match but the wrap bits differ. The head leaving
  // this cycle does not free space for a dispatch in the same cycle.
  assign full = (head[IDX_W] != tail[IDX_W]) && (head_idx == tail_idx);
  assign enq  = dispatch_valid && !full && !cdbus.flush;

  // Head view and issue decision, optionally with same-cycle CDB forwarding.
  always_comb begin
    head_slot = slots[head_idx];
`ifdef MEMQ_CDB_BYPASS_EN
    head_view = memq_capture(head_slot, cdbus);
`else
    head_view = head_slot;
`endif
    issue_valid = memq_ready(head_view);
    if (issue_valid) begin
      issue_entry = head_view.entry;
    end else begin
      issue_entry = '0;
    end
    deq = issue_valid && !mem_stall && !cdbus.flush;
  end

  // Head/tail pointers; wrap-around is the natural overflow of the index.
  always_ff @(posedge clk) begin
    if (rst || cdbus.flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_ONE;
      end else begin
        tail <= tail;
      end
      if (deq) begin
        head <= head + PTR_ONE;
      end else begin
        head <= head;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    memq_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (enq && (tail_idx == IDX_W'(g))),
      .wr_entry (dispatch_entry),
      .deq_en   (deq && (head_idx == IDX_W'(g))),
      .cdbus    (cdbus),
      .slot     (slots[g])
    );
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_mem_issue_queue -- self-checking bench for mem_issue_queue.
//
// Reference model: an ordered list of waiting ops. Each cycle the bench
// predicts full/issue_valid/issue_entry from that list, then advances it by
// the queue's rules (flush/reset empty it, the ready head leaves unless
// stalled, broadcasts fill waiting operands, accepted dispatches append).
// Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_issue_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 dispatch_valid;
  reservation_station_t dispatch_entry;
  logic                 full;
  cdb                   cdbus;
  logic                 mem_stall;
  logic                 issue_valid;
  reservation_station_t issue_entry;

  int n_cmp = 0;
  int n_err = 0;

  reservation_station_t model_q[$];

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_valid (dispatch_valid),
    .dispatch_entry (dispatch_entry),
    .full           (full),
    .cdbus          (cdbus),
    .mem_stall      (mem_stall),
    .issue_valid    (issue_valid),
    .issue_entry    (issue_entry)
  );

  always #5 clk = ~clk;

  // A broadcast fills any operand still waiting on that tag.
  function automatic reservation_station_t grab(reservation_station_t e, cdb c);
    reservation_station_t r;
    r = e;
    if (c.valid && !e.rs1_ready && e.rs1_tag == c.rob_idx) begin
      r.rs1_ready = 1'b1;
      r.rs1_data  = c.data;
    end
    if (c.valid && !e.rs2_ready && e.rs2_tag == c.rob_idx) begin
      r.rs2_ready = 1'b1;
      r.rs2_data  = c.data;
    end
    return r;
  endfunction

  function automatic logic can_go(reservation_station_t e);
    return e.rs1_ready && (e.is_store ? e.rs2_ready : 1'b1);
  endfunction

  function automatic reservation_station_t mk(logic st, logic [4:0] rob,
                                              logic r1, logic [4:0] t1,
                                              logic r2, logic [4:0] t2);
    reservation_station_t e;
    e           = '0;
    e.is_store  = st;
    e.funct3    = 3'b010;
    e.rob_idx   = rob;
    e.rs1_tag   = t1;
    e.rs1_ready = r1;
    e.rs1_data  = r1 ? $urandom() : 32'h0;
    e.rs2_tag   = t2;
    e.rs2_ready = r2;
    e.rs2_data  = r2 ? $urandom() : 32'h0;
    e.imm       = $urandom();
    return e;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_head(output logic v, output reservation_station_t e);
    v = 1'b0;
    e = '0;
    if (model_q.size() > 0) begin
      e = model_q[0];
`ifdef MEMQ_CDB_BYPASS_EN
      e = grab(e, cdbus);
`endif
      v = can_go(e);
    end
    if (!v) e = '0;
  endtask

  // Compare outputs against the model, then advance one clock.
  task automatic tick();
    logic                 ev;
    reservation_station_t ee;
    logic                 took;
    reservation_station_t ne;
    #1;
    exp_head(ev, ee);
    check("full", 128'(full), 128'(model_q.size() == DEPTH));
    check("issue_valid", 128'(issue_valid), 128'(ev));
    check("issue_entry", 128'(issue_entry), 128'(ee));
    took = dispatch_valid && (model_q.size() < DEPTH) && !cdbus.flush;
    ne   = dispatch_entry;
    @(posedge clk);
    if (rst || cdbus.flush) begin
      model_q.delete();
    end else begin
      if (ev && !mem_stall) void'(model_q.pop_front());
      foreach (model_q[i]) model_q[i] = grab(model_q[i], cdbus);
      if (took) model_q.push_back(grab(ne, cdbus));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdbus          = '0;
    mem_stall      = 1'b0;
  endtask

  initial begin
    reservation_station_t e;
    reservation_station_t hold;

    rst = 1'b1;
    dispatch_valid = 1'b0;
    dispatch_entry = '0;
    cdbus = '0;
    mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    #1;
    check("rst_full", 128'(full), 128'(1'b0));
    check("rst_issue_valid", 128'(issue_valid), 128'(1'b0));
    check("rst_issue_entry", 128'(issue_entry), 128'(0));

    // Load with rs1 ready: presented next cycle, gone the cycle after.
    e = mk(1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    dispatch_valid = 1'b1;
    dispatch_entry = e;
    tick();
    dispatch_valid = 1'b0;
    #1;
    check("lw_issue_next", 128'(issue_valid), 128'(1'b1));
    check("lw_entry", 128'(issue_entry), 128'(e));
    tick();
    #1;
    check("lw_drained", 128'(issue_valid), 128'(1'b0));

    // Store waiting on tag 5; broadcast three cycles after dispatch.
    e = mk(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5);
    dispatch_valid = 1'b1;
    dispatch_entry = e;
    tick();
    dispatch_valid = 1'b0;
    tick();
    tick();
    cdbus = '{valid: 1'b1, rob_idx: 5'd5, data: 32'hDEADBEEF, flush: 1'b0};
    #1;
`ifdef MEMQ_CDB_BYPASS_EN
    check("sw_bypass_valid", 128'(issue_valid), 128'(1'b1));
    check("sw_bypass_data", 128'(issue_entry.rs2_data), 128'(32'hDEADBEEF));
    tick();
    cdbus = '0;
`else
    check("sw_wait", 128'(issue_valid), 128'(1'b0));
    tick();
    cdbus = '0;
    #1;
    check("sw_issue", 128'(issue_valid), 128'(1'b1));
    check("sw_data", 128'(issue_entry.rs2_data), 128'(32'hDEADBEEF));
    tick();
`endif

    // Fill to full while stalled, then dispatch in the dequeue cycle.
    mem_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dispatch_valid = 1'b1;
      dispatch_entry = mk(i[0], 5'(10 + i), 1'b1, 5'd0, 1'b1, 5'd0);
      tick();
    end
    dispatch_valid = 1'b0;
    #1;
    check("fill_full", 128'(full), 128'(1'b1));
    mem_stall = 1'b0;
    dispatch_valid = 1'b1;
    dispatch_entry = mk(1'b0, 5'd30, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    #1;
    check("refused_not_full", 128'(full), 128'(1'b0));
    // Ten sequential ops flowing through, wrapping the pointers.
    for (int i = 0; i < 10; i++) begin
      dispatch_valid = 1'b1;
      dispatch_entry = mk(i[1], 5'(i), 1'b1, 5'd0, 1'b1, 5'd0);
      tick();
    end
    idle();
    repeat (10) tick();

    // Stalled head stays put; younger ready op waits behind it.
    mem_stall = 1'b1;
    dispatch_valid = 1'b1;
    dispatch_entry = mk(1'b0, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    dispatch_entry = mk(1'b1, 5'd21, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    #1;
    hold = issue_entry;
    check("stall_head", 128'(hold.rob_idx), 128'(5'd20));
    repeat (4) begin
      tick();
      #1;
      check("stall_hold", 128'(issue_entry), 128'(hold));
    end
    mem_stall = 1'b0;
    tick();
    #1;
    check("stall_next", 128'(issue_entry.rob_idx), 128'(5'd21));
    tick();

    // Flush with five waiting ops and a same-cycle dispatch.
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dispatch_valid = 1'b1;
      dispatch_entry = mk(1'b0, 5'(i), 1'b1, 5'd0, 1'b1, 5'd0);
      tick();
    end
    cdbus.flush = 1'b1;
    dispatch_entry = mk(1'b0, 5'd9, 1'b1, 5'd0, 1'b1, 5'd0);
    tick();
    idle();
    #1;
    check("flush_full", 128'(full), 128'(1'b0));
    check("flush_issue_valid", 128'(issue_valid), 128'(1'b0));
    check("flush_issue_entry", 128'(issue_entry), 128'(0));
    tick();

    // Dispatch that catches its rs1 broadcast in the same cycle.
    dispatch_valid = 1'b1;
    dispatch_entry = mk(1'b0, 5'd4, 1'b0, 5'd3, 1'b0, 5'd0);
    cdbus = '{valid: 1'b1, rob_idx: 5'd3, data: 32'h12345678, flush: 1'b0};
    tick();
    idle();
    #1;
    check("dispatch_capture_valid", 128'(issue_valid), 128'(1'b1));
    check("dispatch_capture_data", 128'(issue_entry.rs1_data), 128'(32'h12345678));
    tick();

    // Randomized traffic with occasional flush and mid-run reset.
    for (int c = 0; c < 500; c++) begin
      rst            = ($urandom_range(0, 149) == 0);
      mem_stall      = ($urandom_range(0, 9) < 3);
      cdbus.valid    = $urandom_range(0, 1) == 1;
      cdbus.rob_idx  = 5'($urandom_range(0, 7));
      cdbus.data     = $urandom();
      cdbus.flush    = ($urandom_range(0, 39) == 0);
      dispatch_valid = ($urandom_range(0, 9) < 6);
      dispatch_entry = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
                          $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)));
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of queue slots (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port dispatch_valid  input  1  a load or store is offered from rename/dispatch.
REQ-005 SHALL have port dispatch_entry  input  reservation_station_t  the offered op, with rs1/rs2 ROB tags and ready flags.
REQ-006 SHALL have port full  output  1  queue cannot accept a dispatch this cycle.
REQ-007 SHALL have port cdbus  input  cdb  writeback broadcast (valid, rob_idx, data, flush).
REQ-008 SHALL have port mem_stall  input  1  the memory unit is busy and the presented op is not taken.
REQ-009 SHALL have port issue_valid  output  1  the head op is presented to the memory unit.
REQ-010 SHALL have port issue_entry  output  reservation_station_t  the head op with resolved rs1_data/rs2_data; all zero when issue_valid=0.

Function
REQ-011 SHALL be a circular FIFO: head and tail pointers of log2(DEPTH)+1 bits, with the extra bit as wrap bit; full = (ptrs equal except wrap bit), empty = (ptrs identical).
REQ-012 SHALL enqueue at tail when dispatch_valid && !full && !cdbus.flush; tail increments with wrap-around.
REQ-013 SHALL refuse dispatch when full even if the head dequeues that same cycle.
REQ-014 SHALL, each cycle, for every valid slot with a non-ready operand whose tag equals cdbus.rob_idx while cdbus.valid, store cdbus.data and set that operand ready.
REQ-015 SHALL apply the REQ-014 capture to an entry being enqueued in the same cycle; the entry is written already ready.
REQ-016 SHALL treat rs2 as always ready for loads; stores require rs1 and rs2.
REQ-017 SHALL issue strictly in program order: issue_valid = head slot valid && all required operands ready.
REQ-018 SHALL dequeue the head when issue_valid && !mem_stall; head increments with wrap-around.
REQ-019 SHALL hold issue_entry bit-stable while issue_valid && mem_stall.
REQ-020 SHALL present an op that was dispatched with all operands ready at issue_valid on the cycle after dispatch (1-cycle latency when empty).
REQ-021 SHALL, on cdbus.flush, invalidate all slots, reset head=tail=0, and drop the same-cycle dispatch and dequeue; issue_valid is 0 on the following cycle.
REQ-022 SHALL allow simultaneous enqueue and dequeue when not full and not empty, leaving the count unchanged.

Reset
REQ-023 SHALL, on rst, clear all slot valid bits and set head=0, tail=0.
REQ-024 SHALL drive full=0, issue_valid=0 and issue_entry='0 in the cycle after rst; rst asserted mid-operation discards all contents.

Configuration
REQ-025 SHALL, with MEMQ_CDB_BYPASS_EN defined, forward cdbus.data combinationally to issue_entry and assert issue_valid in the same cycle that the head's last missing operand is broadcast.
REQ-026 SHALL, without MEMQ_CDB_BYPASS_EN, assert issue_valid no earlier than the cycle after the capture.

Structure
REQ-027 SHALL place memq_slot_t (entry, rs1_rdy, rs2_rdy, valid) and the MEMQ_DEPTH default in rv32i_types.
REQ-028 SHALL implement per-slot operand capture in one sub-module, memq_slot, instantiated DEPTH times.

Verification
REQ-029 SHALL cover: lw dispatched with rs1 ready, mem_stall=0 -> issue_valid=1 next cycle, dequeued after one cycle, queue empty.
REQ-030 SHALL cover: sw with rs2 tag 5 not ready; CDB rob_idx=5, data=0xDEADBEEF three cycles later -> issue_entry.rs2_data=0xDEADBEEF; issue on the following cycle (same cycle with the bypass macro).
REQ-031 SHALL cover: fill 8 entries -> full=1; dispatch+dequeue in same cycle -> dispatch refused, count 7; wrap-around of 10 sequential ops preserves order.
REQ-032 SHALL cover: head ready, mem_stall held 4 cycles -> issue_entry unchanged for 4 cycles; younger ready op is not issued ahead of it.
REQ-033 SHALL cover: flush with 5 entries plus a same-cycle dispatch -> next cycle empty, full=0, issue_valid=0.
REQ-034 SHALL cover: dispatch whose rs1 tag matches a same-cycle CDB broadcast -> entry written with the data already captured and issued next cycle.
